// File: rtl/fir_stream.sv
// Streaming FIR filter with a serially reloadable coefficient bank, a valid/ready
// input handshake, a registered output and a saturating output stage.
module fir_stream #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 18,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     coef_start,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_valid,
    output logic                     coef_busy,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid
);

    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TAPS);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                    state, state_nx;
    logic [CNT_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  s [TAPS-1];
    logic signed [COEF_W-1:0]  c [TAPS];
    logic signed [PROD_W-1:0]  prod [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   sat;
    logic                      accept;

    // Samples are only taken while the coefficient bank is stable and no flush is pending.
    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign coef_busy = (state == LOAD);

    // Loader next-state: start on coef_start, finish after the beat landing in the last tap.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (coef_start) state_nx = LOAD;
            LOAD:    if (coef_valid && cnt == CNT_W'(TAPS - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Loader state register and beat counter; the counter is held at zero while idle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE)
                cnt <= '0;
            else if (coef_valid)
                cnt <= cnt + 1'b1;
        end
    end

    // Coefficient bank: one beat per coef_valid while loading.
    always_ff @(posedge clk) begin
        // NOTE: this bank is cleared explicitly because a reset mid-load must leave all taps at zero, not at stale values.
        if (rst) begin
            for (int k = 0; k < TAPS; k++) c[k] <= '0;
        end else if (state == LOAD && coef_valid) begin
            c[cnt] <= coef_data;
        end
    end

    // Delay line: cleared by reset or flush, shifted on every accepted sample.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < TAPS - 1; k++) s[k] <= '0;
        end else if (accept) begin
            s[0] <= in_data;
            for (int k = 1; k < TAPS - 1; k++) s[k] <= s[k-1];
        end
    end

    // Full-precision multiply-accumulate over the current sample and the delay line.
    always_comb begin
        prod[0] = c[0] * in_data;
        for (int k = 1; k < TAPS; k++) prod[k] = c[k] * s[k-1];
        acc = '0;
        for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
    end

    // Arithmetic shift rounds toward minus infinity.
    assign shifted = acc >>> SHIFT;

    generate
        if (OUT_W < ACC_W) begin : g_clamp
            logic any_ones, all_ones;
            assign any_ones = |shifted[ACC_W-2:OUT_W-1];
            assign all_ones = &shifted[ACC_W-2:OUT_W-1];
            // Clamp when the bits above the output sign are not all copies of the accumulator sign.
            always_comb begin
                if (!shifted[ACC_W-1] && any_ones)
                    sat = {1'b0, {(OUT_W-1){1'b1}}};
                else if (shifted[ACC_W-1] && !all_ones)
                    sat = {1'b1, {(OUT_W-1){1'b0}}};
                else
                    sat = shifted[OUT_W-1:0];
            end
        end else begin : g_extend
            assign sat = OUT_W'(shifted);
        end
    endgenerate

    // Output register: data updates only on accept, valid pulses for exactly that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) out_data <= sat;
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
// Self-checking bench for fir_stream: three instances (plain, 8-bit saturating,
// shift-by-2) share one stimulus stream; an integer model feeds per-instance queues.
module tb_fir_stream;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              flush = 1'b0;
    logic              coef_start = 1'b0;
    logic signed [7:0] coef_data = '0;
    logic              coef_valid = 1'b0;

    logic               rdy_a, rdy_b, rdy_c;
    logic               busy_a, busy_b, busy_c;
    logic               ov_a, ov_b, ov_c;
    logic signed [17:0] od_a, od_c;
    logic signed [7:0]  od_b;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_on   = 1'b0;

    always #5 clk = ~clk;

    fir_stream #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_W(18), .SHIFT(0)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
        .flush(flush), .coef_start(coef_start), .coef_data(coef_data), .coef_valid(coef_valid),
        .coef_busy(busy_a), .out_data(od_a), .out_valid(ov_a));

    fir_stream #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_W(8), .SHIFT(0)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .flush(flush), .coef_start(coef_start), .coef_data(coef_data), .coef_valid(coef_valid),
        .coef_busy(busy_b), .out_data(od_b), .out_valid(ov_b));

    fir_stream #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_W(18), .SHIFT(2)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_c),
        .flush(flush), .coef_start(coef_start), .coef_data(coef_data), .coef_valid(coef_valid),
        .coef_busy(busy_c), .out_data(od_c), .out_valid(ov_c));

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // ---------------- reference model ----------------
    longint m_s [3];
    longint m_c [4];
    bit     m_load = 1'b0;
    int     m_cnt  = 0;
    bit     m_rst  = 1'b0;
    bit     exp_vld = 1'b0;
    longint q_a [$];
    longint q_b [$];
    longint q_c [$];

    always @(posedge clk) begin
        longint acc, d;
        exp_vld = 1'b0;
        m_rst   = rst;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_s[k] = 0;
            for (int k = 0; k < 4; k++) m_c[k] = 0;
            m_load = 1'b0;
            m_cnt  = 0;
        end else begin
            if (!m_load && !flush && in_valid) begin
                d   = in_data;
                acc = m_c[0] * d;
                for (int k = 1; k < 4; k++) acc += m_c[k] * m_s[k-1];
                q_a.push_back(sat(acc, 18));
                q_b.push_back(sat(acc, 8));
                q_c.push_back(sat(acc >>> 2, 18));
                exp_vld = 1'b1;
                m_s[2] = m_s[1];
                m_s[1] = m_s[0];
                m_s[0] = d;
            end
            if (flush) for (int k = 0; k < 3; k++) m_s[k] = 0;
            if (m_load) begin
                if (coef_valid) begin
                    m_c[m_cnt] = coef_data;
                    if (m_cnt == 3) m_load = 1'b0;
                    m_cnt++;
                end
            end else if (coef_start) begin
                m_load = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    // ---------------- monitor (opposite clock edge) ----------------
    longint lexp_a = 0, lexp_b = 0, lexp_c = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (m_rst) begin
                lexp_a = 0; lexp_b = 0; lexp_c = 0;
            end
            check("a_ready", rdy_a, !m_load && !flush);
            check("b_ready", rdy_b, !m_load && !flush);
            check("c_ready", rdy_c, !m_load && !flush);
            check("a_busy", busy_a, m_load);
            check("b_busy", busy_b, m_load);
            check("c_busy", busy_c, m_load);
            check("a_valid", ov_a, exp_vld);
            check("b_valid", ov_b, exp_vld);
            check("c_valid", ov_c, exp_vld);
            if (ov_a) begin
                check("a_queue_nonempty", q_a.size() > 0, 1);
                if (q_a.size() > 0) lexp_a = q_a.pop_front();
            end
            if (ov_b) begin
                check("b_queue_nonempty", q_b.size() > 0, 1);
                if (q_b.size() > 0) lexp_b = q_b.pop_front();
            end
            if (ov_c) begin
                check("c_queue_nonempty", q_c.size() > 0, 1);
                if (q_c.size() > 0) lexp_c = q_c.pop_front();
            end
            check("a_data", od_a, lexp_a);
            check("b_data", od_b, lexp_b);
            check("c_data", od_c, lexp_c);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample(input int d);
        in_valid = 1'b1;
        in_data  = 8'(d);
        step();
        in_valid = 1'b0;
    endtask

    // coef_start cycle carries a bogus beat that must be ignored.
    task automatic load(input int c0, input int c1, input int c2, input int c3, input bit gaps);
        int cs [4];
        cs = '{c0, c1, c2, c3};
        coef_start = 1'b1;
        coef_valid = 1'b1;
        coef_data  = 8'sd99;
        step();
        coef_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            coef_valid = 1'b1;
            coef_data  = 8'(cs[k]);
            #1;
            check("load_ready", rdy_a, 0);
            check("load_busy", busy_a, 1);
            step();
            coef_valid = 1'b0;
            check("load_out_valid", ov_a, 0);
            if (gaps && k < 3) begin
                step();
                check("gap_out_valid", ov_a, 0);
            end
        end
        #1;
        check("load_done_busy", busy_a, 0);
    endtask

    initial begin
        int imp_in  [5];
        int imp_exp [5];
        imp_in  = '{10, 0, 0, 0, 0};
        imp_exp = '{10, 20, 30, 40, 0};

        step();
        mon_on = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("reset_ready", rdy_a, 1);
        check("reset_busy", busy_a, 0);
        check("reset_valid", ov_a, 0);
        check("reset_data", od_a, 0);

        // impulse response
        load(1, 2, 3, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sample(imp_in[i]);
            check("impulse_data", od_a, imp_exp[i]);
            check("impulse_valid", ov_a, 1);
        end

        // flush blocks the accept and clears history
        sample(10);
        in_valid = 1'b1;
        in_data  = 8'sd5;
        flush    = 1'b1;
        #1;
        check("flush_ready", rdy_a, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_no_valid", ov_a, 0);
        sample(0);
        check("flush_after", od_a, 0);

        // shift with floor rounding
        load(1, 0, 0, 0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        sample(-5);
        check("floor_neg", od_c, -2);
        check("noshift_neg", od_a, -5);
        sample(7);
        check("floor_pos", od_c, 1);

        // saturation at both rails
        load(127, 127, 127, 127, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) sample(127);
        check("sat_pos", od_b, 127);
        check("sat_pos_full", od_a, 64516);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) sample(-128);
        check("sat_neg", od_b, -128);
        check("sat_neg_full", od_a, -65024);

        // held input across a gapped load: history survives, new taps apply
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd3;
        repeat (3) step();
        load(2, 0, 0, 1, 1'b1);
        check("hs_ready_after", rdy_a, 1);
        step();
        check("hs_first_out", od_a, 9);
        check("hs_first_valid", ov_a, 1);
        in_valid = 1'b0;

        // reset in the middle of a load
        coef_start = 1'b1;
        step();
        coef_start = 1'b0;
        coef_valid = 1'b1;
        coef_data  = 8'sd5;
        repeat (2) step();
        coef_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_ready", rdy_a, 1);
        sample(50);
        check("rst_mid_data", od_a, 0);
        check("rst_mid_valid", ov_a, 1);

        repeat (2) step();
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        check("c_queue_drained", q_c.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fir_stream.md
# fir_stream

Parametrised streaming FIR filter with run-time loadable coefficients, valid/ready input handshake, a registered output and a saturating output stage. It generalises the fixed 4-tap, 8-bit filter to arbitrary tap count and widths. It sits in the sample datapath between an upstream sample source and a downstream consumer. A serial coefficient-load state machine reprograms the taps without a reset.

## Interface
- TAPS, 4, number of taps (≥2)
- DATA_W, 8, signed sample width
- COEF_W, 8, signed coefficient width
- OUT_W, 18, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0 ≤ SHIFT < ACC_W)
- Derived: ACC_W = DATA_W + COEF_W + $clog2(TAPS)
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_data  in  DATA_W  signed input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  filter accepts a sample this cycle
- flush  in  1  clear the delay line (coefficients kept)
- coef_start  in  1  begin a coefficient load
- coef_data  in  COEF_W  signed coefficient beat
- coef_valid  in  1  coefficient beat valid
- coef_busy  out  1  coefficient load in progress
- out_data  out  OUT_W  signed filter result
- out_valid  out  1  out_data valid; one-cycle pulse per accepted sample

## Operation
- Delay line s[0..TAPS-2] holds past samples; s[0] is the newest. Coefficient bank c[0..TAPS-1] applies c[0] to the current sample and c[k] to the sample k accepts ago.
- Accept condition: in_valid && in_ready. On accept: acc = c[0]*in_data + Σ c[k]*s[k-1] (k=1..TAPS-1), full precision in ACC_W bits. Then s shifts: s[0] ← in_data and s[k] ← s[k-1].
- Output: r = acc >>> SHIFT (arithmetic shift, floor). out_data = r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The clamp is a no-op when OUT_W ≥ ACC_W-SHIFT.
- in_ready = (state==IDLE) && !flush. There is no output backpressure.
- FSM states:
  - IDLE → LOAD on coef_start; the beat counter is cleared.
  - LOAD: each coef_valid writes coef_data into c[cnt] and increments cnt. After the beat with cnt==TAPS-1, the FSM returns to IDLE.
  - coef_busy = (state==LOAD).
- Ignored inputs:
  - coef_start while in LOAD.
  - coef_valid while in IDLE.
  - The same-cycle coef_valid on the coef_start cycle; the first beat is taken on the cycle after.
- During LOAD, partially written coefficients are not used because no sample is accepted. The delay line is preserved across a load.
- flush: all s[k] ← 0 on that edge, and no sample is accepted that cycle. Flush may be asserted in IDLE or LOAD; it does not alter the FSM or the coefficients.

## Timing
- Reset values:
  - s[k] = 0 and c[k] = 0; state IDLE, cnt = 0.
  - out_data = 0, out_valid = 0, coef_busy = 0.
  - in_ready = 1 on the first cycle after reset, unless flush is asserted.
- Latency: a sample accepted at edge t produces out_valid=1 and its out_data after edge t, i.e. one cycle. out_data holds its value until the next accept. out_valid is low in every cycle without an accept.
- Throughput: one sample per cycle in IDLE.
- Coefficient load: coef_start at edge t puts coef_busy high after t. TAPS beats are taken on their coef_valid edges; gaps are allowed. coef_busy falls after the edge of the last beat, and in_ready is high the following cycle. The new coefficients apply to the first sample accepted after that.
- rst mid-load: FSM returns to IDLE, all coefficients are zeroed, and the partial load is discarded.
- rst has priority over flush, coef_start and sample accept.

## Test plan
- Impulse response: TAPS=4, coefficients loaded as 1,2,3,4; input 10,0,0,0,0 (one per cycle) → out_data 10,20,30,40,0, each with a one-cycle out_valid.
- Saturation: OUT_W=8, SHIFT=0, all coefficients 127; four inputs of 127 → final out_data=127. Four inputs of -128 → final out_data=-128.
- Shift/floor: SHIFT=2, coefficients 1,0,0,0; input -5 → out_data=-2. Input 7 → out_data=1.
- Handshake during load: hold in_valid=1 with a constant 3, pulse coef_start, give TAPS beats with one-cycle gaps.
  - in_ready stays 0 and out_valid stays 0 throughout the load.
  - The first output after coef_busy falls uses the new coefficients and the pre-load delay line.
- Flush: after the impulse of 10 with coefficients 1,2,3,4, assert flush together with in_valid → no accept that cycle. The next accepted input of 0 gives out_data=0.
- Reset mid-load: rst after 2 of 4 beats → coef_busy=0 and in_ready=1 next cycle. Input 50 → out_data=0 (coefficients zeroed).
